// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned CNT_W_DEF = 6;

    // Quotient returned for any division by zero.
    localparam logic [WIDTH_DEF-1:0] DIV0_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/iter_divider_if.sv
// Request/result handshake between the ALU (master) and the divider (slave).
interface iter_divider_if
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
);

    logic             div;
    logic             div_signed;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             complete;

    modport master (
        output div, div_signed, x, y,
        input  s, r, complete
    );

    modport slave (
        input  div, div_signed, x, y,
        output s, r, complete
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_c_o,
    output logic             qbit_c_o
);

    logic [WIDTH:0] partial;

    // Shift the next dividend bit in and subtract when the divisor fits.
    always_comb begin
        partial  = {rem_i, bit_i};
        qbit_c_o = (partial >= {1'b0, dvsr_i});
        rem_c_o  = qbit_c_o ? WIDTH'(partial - {1'b0, dvsr_i}) : partial[WIDTH-1:0];
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider, signed and unsigned.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and
// completes one cycle after the request.
module iter_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          resetn,
    iter_divider_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dq_q, dq_d;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] ymag_q, ymag_d;
    logic [WIDTH-1:0] x_q, x_d;        // original dividend, returned on divide by zero
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             complete_q, complete_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic [WIDTH-1:0] quo_next;
    logic             x_neg;
    logic             y_neg;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + WIDTH'(1)) : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i    (rem_q),
        .bit_i    (dq_q[WIDTH-1]),
        .dvsr_i   (ymag_q),
        .rem_c_o  (step_rem),
        .qbit_c_o (step_qbit)
    );

    assign quo_next = {dq_q[WIDTH-2:0], step_qbit};
    assign x_neg    = bus.div_signed & bus.x[WIDTH-1];
    assign y_neg    = bus.div_signed & bus.y[WIDTH-1];

    // Next-state, datapath and result update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dq_d       = dq_q;
        rem_d      = rem_q;
        ymag_d     = ymag_q;
        x_d        = x_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        s_d        = s_q;
        r_d        = r_q;
        complete_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.div) begin
                    x_d     = bus.x;
                    dq_d    = neg_if(bus.x, x_neg);
                    ymag_d  = neg_if(bus.y, y_neg);
                    qneg_d  = x_neg ^ y_neg;
                    rneg_d  = x_neg;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef DIV_ZERO_FAST_EN
                    if (bus.y == '0) begin
                        s_d        = WIDTH'(DIV0_QUOT);
                        r_d        = bus.x;
                        complete_d = 1'b1;
                        state_d    = DONE;
                    end
`endif
                end
            end
            RUN: begin
                if (!bus.div) begin
                    state_d = IDLE;
                end else begin
                    dq_d  = quo_next;
                    rem_d = step_rem;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        complete_d = 1'b1;
                        state_d    = DONE;
                        if (ymag_q == '0) begin
                            s_d = WIDTH'(DIV0_QUOT);
                            r_d = x_q;
                        end else begin
                            s_d = neg_if(quo_next, qneg_q);
                            r_d = neg_if(step_rem, rneg_q);
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dq_q       <= '0;
            rem_q      <= '0;
            ymag_q     <= '0;
            x_q        <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            s_q        <= '0;
            r_q        <= '0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dq_q       <= dq_d;
            rem_q      <= rem_d;
            ymag_q     <= ymag_d;
            x_q        <= x_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            s_q        <= s_d;
            r_q        <= r_d;
            complete_q <= complete_d;
        end
    end

    assign bus.s        = s_q;
    assign bus.r        = r_q;
    assign bus.complete = complete_q;

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: driver pushes expected results, monitor checks on complete.
module tb_iter_divider;

    typedef struct {
        logic [31:0] s;
        logic [31:0] r;
        int          due;
        string       name;
    } exp_t;

`ifdef DIV_ZERO_FAST_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = 33;
`endif

    logic  clk;
    logic  resetn;
    int    cyc;
    int    tests;
    int    fails;
    exp_t  sb[$];
    logic [31:0] last_s;
    logic [31:0] last_r;

    iter_divider_if #(.WIDTH(32)) bus ();

    iter_divider dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every complete pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetn && bus.complete === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_complete: got complete=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_s"}, bus.s, e.s);
                check({e.name, "_r"}, bus.r, e.r);
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
            end
        end
    end

    // Issue one request, hold div until complete, then drop it.
    task automatic run_op(input string name, input logic sg, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] es, input logic [31:0] er, input int lat);
        exp_t e;
        bit   seen;
        @(posedge clk); #1;
        bus.div = 1'b1; bus.div_signed = sg; bus.x = x; bus.y = y;
        e.s = es; e.r = er; e.due = cyc + lat; e.name = name;
        sb.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.complete === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no complete expected complete within 40 cycles", name);
            sb.delete();
        end
        @(posedge clk); #1;
        bus.div = 1'b0;
        @(negedge clk);
        check({name, "_pulse_end"}, 32'(bus.complete), 32'd0);
        last_s = es;
        last_r = er;
    endtask

    initial begin
        cyc = 0; tests = 0; fails = 0;
        last_s = '0; last_r = '0;
        bus.div = 1'b0; bus.div_signed = 1'b0; bus.x = '0; bus.y = '0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_s", bus.s, 32'd0);
        check("reset_r", bus.r, 32'd0);
        check("reset_complete", 32'(bus.complete), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        run_op("u_100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33);
        run_op("s_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33);
        run_op("s_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33);
        run_op("u_fff9_2",   1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          33);
        run_op("s_min_m1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33);
        run_op("u_max_1",    1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33);
        run_op("s_5_0",      1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          DIV0_LAT);
        run_op("u_5_0",      1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          DIV0_LAT);
        run_op("s_m8_0",     1'b1, 32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF8,  DIV0_LAT);

        // Abort: drop div at cycle 10 of 1000/3; no completion, results untouched.
        @(posedge clk); #1;
        bus.div = 1'b1; bus.div_signed = 1'b0; bus.x = 32'd1000; bus.y = 32'd3;
        repeat (10) @(posedge clk);
        #1 bus.div = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_s_hold", bus.s, last_s);
        check("abort_r_hold", bus.r, last_r);
        run_op("u_9_3_after_abort", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        // Reset in the middle of 50/5.
        @(posedge clk); #1;
        bus.div = 1'b1; bus.div_signed = 1'b0; bus.x = 32'd50; bus.y = 32'd5;
        repeat (20) @(posedge clk);
        #1 resetn = 1'b0;
        bus.div = 1'b0;
        #1;
        check("midreset_s", bus.s, 32'd0);
        check("midreset_r", bus.r, 32'd0);
        check("midreset_complete", 32'(bus.complete), 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        run_op("u_50_5_after_reset", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 33);

        repeat (5) @(posedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle 32-bit radix-2 restoring divider. It is the responder side of the ALU's div/complete handshake.
- The ALU execute stage holds `div` high with operands. The block computes quotient and remainder, then pulses `complete`.
- Supports signed (DIV/MOD) and unsigned (DIVU/MODU) modes with one shared datapath.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is verified.
- CNT_W, 6, iteration counter width. Must hold the value WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- div  input  1  request level. Held high by the ALU until `complete`; deassertion aborts.
- div_signed  input  1  1 = signed (two's complement), 0 = unsigned. Sampled at start.
- x  input  WIDTH  dividend, sampled at start.
- y  input  WIDTH  divisor, sampled at start.
- s  output  WIDTH  quotient, registered.
- r  output  WIDTH  remainder, registered.
- complete  output  1  one-cycle pulse; s/r valid in that cycle.

Behaviour:
- Reset (async, resetn=0): state IDLE, counter 0, s=0, r=0, complete=0. This applies at any time, including mid-operation; no partial result is ever exposed.
- States: IDLE, RUN, DONE.
- IDLE:
  - If div=1, latch div_signed, |x|, |y|, quotient sign (x[31]^y[31]) and remainder sign (x[31]). Magnitudes are taken only when signed.
  - Clear the partial remainder and counter, then go to RUN. Otherwise stay in IDLE.
- RUN, one iteration per cycle, MSB first:
  - partial = {rem, next dividend bit}.
  - If partial >= |y|: rem = partial-|y|, quotient bit = 1. Otherwise rem = partial, quotient bit = 0.
  - counter++. After WIDTH iterations go to DONE.
- DONE:
  - Write s and r: negate the quotient if its sign is set; negate the remainder if its sign is set.
  - Assert complete=1 for exactly this cycle, then go to IDLE.
- Latency: div first seen high in cycle 0 → complete high in cycle WIDTH+1 (33).
- complete is a registered state decode; it is never combinational from div.
- s/r hold their value from DONE until the next DONE or reset. The ALU samples them only while complete=1.
- Abort: div=0 in any RUN cycle → IDLE next cycle. No complete; s/r unchanged.
- Back-to-back: DONE always returns to IDLE. If div is still high in IDLE, a new operation starts on whatever operands are present. The upstream pipeline guarantees a new request follows complete only when a new div instruction is in execute.
- x/y/div_signed changes during RUN are ignored.
- Arithmetic rules:
  - The remainder takes the dividend's sign; the quotient truncates toward zero.
  - 0x80000000 / 0xFFFFFFFF signed → s=0x80000000, r=0 (wraps, no trap).
- Divide by zero (y=0), both modes: forced result s=0xFFFFFFFF, r=x (original, unnegated).

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: y=0 detected in IDLE at start goes directly to DONE. complete in cycle 1, same forced result.
- Undefined: y=0 runs the full 33-cycle sequence. The forced result is applied in DONE.
- Non-zero divisors are unaffected either way.

Decomposition:
- Package div_pkg:
  - state enum (IDLE/RUN/DONE), 2-bit encoding.
  - WIDTH and CNT_W defaults.
  - DIV0_QUOT constant (all ones).
- Sub-module div_step: combinational single restoring step.
  - Inputs: rem, dividend bit, divisor magnitude.
  - Outputs: next rem, quotient bit.
- Sign handling and the FSM stay in iter_divider.

Test Plan:
- Unsigned 100/7 (div_signed=0), div held → complete in cycle 33 only; s=14, r=2; complete low in cycle 34.
- Signed -7/2 (x=0xFFFFFFF9, y=2) → s=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7/-2 → s=0xFFFFFFFD, r=1.
- Signed 0x80000000/0xFFFFFFFF → s=0x80000000, r=0. Unsigned 0xFFFFFFFF/1 → s=0xFFFFFFFF, r=0.
- Divide by zero 5/0, signed and unsigned → s=0xFFFFFFFF, r=5. complete at cycle 33, or cycle 1 with DIV_ZERO_FAST_EN.
- Abort: start 1000/3, drop div at cycle 10 → no complete, s/r unchanged. Restart with 9/3 → complete at cycle 33 of the new request; s=3, r=0.
- Reset: resetn=0 at cycle 20 of 50/5 → immediately s=0, r=0, complete=0. After release, a new 50/5 → s=10, r=0 at cycle 33.
